// File: rtl/wb_bridge_arbiter.sv
// Round-robin arbiter sharing one Wishbone initiator port of the clock-domain
// bridge among N_INIT initiators. The grant is held for the owner's whole cyc
// period. A late ack from an abandoned transfer is drained so that it never
// reaches the next owner.
module wb_bridge_arbiter #(
  parameter int ADR_WIDTH     = 32,
  parameter int DAT_WIDTH     = 32,
  parameter int N_INIT        = 2,
  parameter int DRAIN_TIMEOUT = 1023
) (
  input  logic                            reset,
  input  logic                            i_clock,
  input  logic [N_INIT*ADR_WIDTH-1:0]     m_adr,
  input  logic [N_INIT*DAT_WIDTH-1:0]     m_dat_w,
  input  logic [N_INIT*(DAT_WIDTH/8)-1:0] m_sel,
  input  logic [N_INIT-1:0]               m_we,
  input  logic [N_INIT-1:0]               m_cyc,
  input  logic [N_INIT-1:0]               m_stb,
  output logic [DAT_WIDTH-1:0]            m_dat_r,
  output logic [N_INIT-1:0]               m_ack,
  output logic [ADR_WIDTH-1:0]            t_adr,
  output logic [DAT_WIDTH-1:0]            t_dat_w,
  output logic [DAT_WIDTH/8-1:0]          t_sel,
  output logic                            t_we,
  output logic                            t_cyc,
  output logic                            t_stb,
  input  logic [DAT_WIDTH-1:0]            t_dat_r,
  input  logic                            t_ack,
  output logic [N_INIT-1:0]               gnt,
  output logic                            drain_err
);

  localparam int          SEL_W = DAT_WIDTH / 8;
  localparam int          IDX_W = (N_INIT > 1) ? $clog2(N_INIT) : 1;
  localparam int          CNT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned NI    = N_INIT;

  typedef enum logic [1:0] {IDLE, OWNED, DRAIN, GAP} state_t;

  state_t             state_q;
  logic [N_INIT-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, winner_d;
  logic               outst_q, outst_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_found;
  logic               timeout;

  // Round-robin search: first requester after the previous owner, wrapping.
  always_comb begin
    int unsigned target;
    target    = 0;
    req_found = 1'b0;
    winner_d  = last_q;
    gnt_d     = '0;
    for (int unsigned i = 1; i <= NI; i++) begin
      target = 32'(last_q) + i;
      if (target >= NI) target = target - NI;
      for (int unsigned j = 0; j < NI; j++) begin
        if (!req_found && target == j && m_cyc[j]) begin
          req_found = 1'b1;
          winner_d  = IDX_W'(j);
          gnt_d     = '0;
          gnt_d[j]  = 1'b1;
        end
      end
    end
  end

  // Owner's request routed to the bridge and ack routed back, only while OWNED.
  always_comb begin
    t_cyc   = 1'b0;
    t_stb   = 1'b0;
    t_adr   = '0;
    t_dat_w = '0;
    t_sel   = '0;
    t_we    = 1'b0;
    m_ack   = '0;
    for (int unsigned k = 0; k < NI; k++) begin
      if (state_q == OWNED && last_q == IDX_W'(k)) begin
        t_cyc    = m_cyc[k];
        t_stb    = m_cyc[k] & m_stb[k];
        t_adr    = m_adr[k*ADR_WIDTH +: ADR_WIDTH];
        t_dat_w  = m_dat_w[k*DAT_WIDTH +: DAT_WIDTH];
        t_sel    = m_sel[k*SEL_W +: SEL_W];
        t_we     = m_we[k];
        m_ack[k] = t_ack & m_cyc[k] & m_stb[k];
      end
    end
  end

  assign outst_d   = t_stb & ~t_ack;
  assign timeout   = (cnt_q == CNT_W'(DRAIN_TIMEOUT));
  // A real ack in the final drain cycle resolves the drain, so no error then.
  assign drain_err = (state_q == DRAIN) && timeout && !t_ack;
  assign m_dat_r   = t_dat_r;
  assign gnt       = gnt_q;

  // Arbitration state machine: grant, hold, optional drain, one-cycle gap.
  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(N_INIT - 1);
      outst_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_found) begin
            state_q <= OWNED;
            gnt_q   <= gnt_d;
            last_q  <= winner_d;
          end
        end
        OWNED: begin
          outst_q <= outst_d;
          // An ack landing in the drop cycle completes the pending strobe.
          if (!t_cyc) state_q <= (outst_q && !t_ack) ? DRAIN : GAP;
        end
        DRAIN: begin
          if (t_ack || timeout) begin
            state_q <= GAP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
